// File: rtl/cp0_ctrl_if.sv
// CP0 pipeline-side bus: mtc0/mfc0 ports, exception/eret commit and the status outputs.
// The pipeline drives through the master modport; cp0_ctrl sits on the slave modport.
interface cp0_ctrl_if #(
    parameter int HW_INT_NUM = 6
);
    logic [4:0]            raddr_i;
    logic                  we_i;
    logic [4:0]            waddr_i;
    logic [31:0]           wdata_i;
    logic [HW_INT_NUM-1:0] int_i;
    logic                  exc_valid_i;
    logic [4:0]            exc_code_i;
    logic [31:0]           exc_pc_i;
    logic                  exc_bd_i;
    logic [31:0]           exc_badvaddr_i;
    logic                  eret_i;
    logic [31:0]           data_o;
    logic [31:0]           status_o;
    logic [31:0]           cause_o;
    logic [31:0]           epc_o;
    logic                  int_pending_o;
    logic                  timer_int_o;

    modport master (
        output raddr_i, we_i, waddr_i, wdata_i, int_i,
               exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        input  data_o, status_o, cause_o, epc_o, int_pending_o, timer_int_o
    );

    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i, int_i,
               exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        output data_o, status_o, cause_o, epc_o, int_pending_o, timer_int_o
    );
endinterface

// File: rtl/cp0_ctrl.sv
// CP0 register block: Count/Compare timer, Status, Cause, EPC, BadVAddr, PRId, Config,
// exception commit, ERET and interrupt-pending. Define CP0_TIMER_EN to build Compare and the timer.
module cp0_ctrl #(
    parameter int          HW_INT_NUM   = 6,
    parameter int          COUNT_DIV    = 1,
    parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
    parameter logic [31:0] STATUS_RST   = 32'h1000_0000,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input  logic       clk,
    input  logic       rst,
    cp0_ctrl_if.slave  bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;
    localparam int          DIV_W       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [31:0]           status_q, epc_q, badvaddr_q, count_q;
    logic [DIV_W-1:0]      div_q;
    logic                  bd_q, pend_q;
    logic [4:0]            exccode_q;
    logic [1:0]            ivwp_q, ipsw_q;
    logic [HW_INT_NUM-1:0] iphw_q;
    logic [7:0]            ip;
    logic [31:0]           cause_val, compare_val, rdata;
    logic                  timer_val;
    logic                  wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic                  div_wrap;
    logic [31:0]           count_inc;

    assign wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
    assign wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
    assign wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
    assign wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
    assign wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);
    assign div_wrap   = (div_q == DIV_W'(COUNT_DIV - 1));
    assign count_inc  = count_q + 32'd1;

`ifdef CP0_TIMER_EN
    logic [31:0] compare_q;
    logic        timer_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else if (wr_compare) begin
            // Writing Compare acknowledges the timer, even against a same-cycle match
            compare_q <= bus.wdata_i;
            timer_q   <= 1'b0;
        end else if (!wr_count && div_wrap && (compare_q != 32'd0) && (count_inc == compare_q)) begin
            timer_q <= 1'b1;
        end
    end

    assign compare_val = compare_q;
    assign timer_val   = timer_q;
`else
    assign compare_val = 32'd0;
    assign timer_val   = 1'b0;
`endif

    always_comb begin
        ip             = '0;
        ip[1:0]        = ipsw_q;
        ip[2+:HW_INT_NUM] = iphw_q;
        ip[7]          = ip[7] | timer_val;
        cause_val      = {bd_q, 7'b0, ivwp_q, 6'b0, ip, 1'b0, exccode_q, 2'b0};
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.raddr_i)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_val;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause_val;
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID_VALUE;
            REG_CONFIG:   rdata = CONFIG_VALUE;
            default:      rdata = 32'd0;
        endcase
        // Same-cycle mtc0 forwarding; read-only and unmapped indices are not forwarded
        if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
            case (bus.raddr_i)
                REG_COUNT, REG_STATUS, REG_EPC: rdata = bus.wdata_i;
`ifdef CP0_TIMER_EN
                REG_COMPARE: rdata = bus.wdata_i;
`endif
                REG_CAUSE: rdata = (cause_val & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK);
                default:   rdata = rdata;
            endcase
        end
        if (rst) rdata = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            div_q      <= '0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ivwp_q     <= '0;
            ipsw_q     <= '0;
            iphw_q     <= '0;
            pend_q     <= 1'b0;
        end else begin
            iphw_q <= bus.int_i;
            pend_q <= status_q[0] & ~status_q[1] & (|(ip & status_q[15:8]));

            if (wr_count) begin
                count_q <= bus.wdata_i;
                div_q   <= '0;
            end else if (div_wrap) begin
                count_q <= count_inc;
                div_q   <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            if (wr_status) status_q <= bus.wdata_i;
            if (wr_cause) begin
                ivwp_q <= bus.wdata_i[23:22];
                ipsw_q <= bus.wdata_i[9:8];
            end

            // Exception owns EXL and EPC this cycle; later assignments override the mtc0 EXL bit
            if (bus.exc_valid_i) begin
                status_q[1] <= 1'b1;
                exccode_q   <= bus.exc_code_i;
                if (!status_q[1]) begin
                    epc_q <= bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
                    bd_q  <= bus.exc_bd_i;
                end
                if ((bus.exc_code_i == 5'd4) || (bus.exc_code_i == 5'd5))
                    badvaddr_q <= bus.exc_badvaddr_i;
            end else begin
                if (bus.eret_i) status_q[1] <= 1'b0;
                if (wr_epc) epc_q <= bus.wdata_i;
            end
        end
    end

    assign bus.data_o        = rdata;
    assign bus.status_o      = status_q;
    assign bus.cause_o       = cause_val;
    assign bus.epc_o         = epc_q;
    assign bus.int_pending_o = pend_q;
    assign bus.timer_int_o   = timer_val;
endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed CP0 scenarios followed by a randomized run checked against a cycle model.
module tb_cp0_ctrl;
    localparam int          HW   = 4;
    localparam int          DIV  = 4;
    localparam logic [31:0] PRID = 32'h0048_0102;
    localparam logic [31:0] SRST = 32'h1000_0000;
    localparam logic [31:0] CFG  = 32'h0000_8000;
    localparam logic [31:0] WMASK = 32'h00C0_0300;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_ctrl_if #(.HW_INT_NUM(HW)) bus ();
    cp0_ctrl #(.HW_INT_NUM(HW), .COUNT_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int passed = 0, fails = 0, total = 0;

    // Reference state: Count is base plus elapsed ticks divided down
    logic [31:0]    m_status, m_epc, m_badv, m_base, m_compare;
    int             m_ticks;
    logic           m_timer, m_bd, m_pend;
    logic [4:0]     m_exc;
    logic [1:0]     m_ivwp, m_ipsw;
    logic [HW-1:0]  m_iphw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_ticks / DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        logic [7:0] ip = 8'd0;
        ip[1:0] = m_ipsw;
        for (int k = 0; k < HW; k++) ip[2+k] = m_iphw[k];
        ip[7] = ip[7] | m_timer;
        return ip;
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, 7'b0, m_ivwp, 6'b0, m_ip(), 1'b0, m_exc, 2'b0};
    endfunction

    function automatic logic [31:0] m_read();
        logic [31:0] v;
        case (bus.raddr_i)
            5'd8:  v = m_badv;
            5'd9:  v = m_count();
`ifdef CP0_TIMER_EN
            5'd11: v = m_compare;
`endif
            5'd12: v = m_status;
            5'd13: v = m_cause();
            5'd14: v = m_epc;
            5'd15: v = PRID;
            5'd16: v = CFG;
            default: v = 32'd0;
        endcase
        if (bus.we_i && bus.waddr_i == bus.raddr_i) begin
            if (bus.raddr_i inside {5'd9, 5'd12, 5'd14}) v = bus.wdata_i;
`ifdef CP0_TIMER_EN
            if (bus.raddr_i == 5'd11) v = bus.wdata_i;
`endif
            if (bus.raddr_i == 5'd13) v = (m_cause() & ~WMASK) | (bus.wdata_i & WMASK);
        end
        if (rst) v = 32'd0;
        return v;
    endfunction

    task automatic model_step();
        logic [31:0] oldc, newc;
        logic old_exl;
        if (rst) begin
            m_status = SRST; m_epc = 0; m_badv = 0; m_base = 0; m_compare = 0; m_ticks = 0;
            m_timer = 0; m_bd = 0; m_pend = 0; m_exc = 0; m_ivwp = 0; m_ipsw = 0; m_iphw = 0;
            return;
        end
        old_exl = m_status[1];
        m_pend = m_status[0] & ~m_status[1] & (|(m_ip() & m_status[15:8]));
        m_iphw = bus.int_i;
        if (bus.we_i && bus.waddr_i == 5'd9) begin
            m_base = bus.wdata_i; m_ticks = 0;
        end else begin
            oldc = m_count();
            m_ticks++;
            newc = m_count();
`ifdef CP0_TIMER_EN
            if (newc != oldc && m_compare != 0 && newc == m_compare) m_timer = 1'b1;
`endif
        end
`ifdef CP0_TIMER_EN
        if (bus.we_i && bus.waddr_i == 5'd11) begin m_compare = bus.wdata_i; m_timer = 1'b0; end
`endif
        if (bus.we_i && bus.waddr_i == 5'd12) m_status = bus.wdata_i;
        if (bus.we_i && bus.waddr_i == 5'd13) begin
            m_ivwp = bus.wdata_i[23:22]; m_ipsw = bus.wdata_i[9:8];
        end
        if (bus.exc_valid_i) begin
            m_status[1] = 1'b1;
            m_exc = bus.exc_code_i;
            if (!old_exl) begin
                m_epc = bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
                m_bd  = bus.exc_bd_i;
            end
            if (bus.exc_code_i == 5'd4 || bus.exc_code_i == 5'd5) m_badv = bus.exc_badvaddr_i;
        end else begin
            if (bus.eret_i) m_status[1] = 1'b0;
            if (bus.we_i && bus.waddr_i == 5'd14) m_epc = bus.wdata_i;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.raddr_i = 0; bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0; bus.int_i = 0;
        bus.exc_valid_i = 0; bus.exc_code_i = 0; bus.exc_pc_i = 0; bus.exc_bd_i = 0;
        bus.exc_badvaddr_i = 0; bus.eret_i = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1; bus.waddr_i = a; bus.wdata_i = d;
        tick();
        bus.we_i = 0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.raddr_i = a;
        #1;
        chk(tag, bus.data_o, exp);
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd, input logic [31:0] bva);
        bus.exc_valid_i = 1; bus.exc_code_i = code; bus.exc_pc_i = pc; bus.exc_bd_i = bd;
        bus.exc_badvaddr_i = bva;
        tick();
        bus.exc_valid_i = 0;
    endtask

    initial begin
        int addrs[10] = '{8, 9, 11, 12, 13, 14, 15, 16, 3, 31};
        idle();
        rst = 1;
        bus.raddr_i = 5'd15;
        tick();
        #1 chk("data_in_rst", bus.data_o, 32'd0);
        rst = 0;
        rd("rst_status", 12, SRST);
        rd("rst_prid", 15, PRID);
        rd("rst_config", 16, CFG);
        rd("rst_count", 9, 32'd0);
        chk("rst_pend", bus.int_pending_o, 0);
        chk("rst_timer", bus.timer_int_o, 0);

        mtc0(9, 32'd5);
        repeat (8) tick();
        rd("count_div", 9, 32'd7);
        mtc0(9, 32'hFFFF_FFFF);
        repeat (4) tick();
        rd("count_wrap", 9, 32'd0);

        mtc0(12, 32'h0000_8001);
        mtc0(11, 32'd10);
        mtc0(9, 32'd8);
        repeat (7) tick();
        rd("count_pre", 9, 32'd9);
        chk("timer_pre", bus.timer_int_o, 0);
        tick();
`ifdef CP0_TIMER_EN
        rd("compare_rd", 11, 32'd10);
        chk("timer_set", bus.timer_int_o, 1);
        chk("pend_lag", bus.int_pending_o, 0);
        tick();
        chk("pend_set", bus.int_pending_o, 1);
        repeat (3) tick();
        chk("timer_sticky", bus.timer_int_o, 1);
        mtc0(11, 32'd20);
        chk("timer_clr", bus.timer_int_o, 0);
        mtc0(11, 32'd0);
        chk("pend_clr", bus.int_pending_o, 0);
`else
        rd("compare_rd", 11, 32'd0);
        chk("timer_off", bus.timer_int_o, 0);
        repeat (4) tick();
        chk("pend_off", bus.int_pending_o, 0);
`endif

        exc(5'd4, 32'h100, 1'b1, 32'h33);
        chk("exc_epc", bus.epc_o, 32'hFC);
        chk("exc_cause", bus.cause_o, 32'h8000_0010);
        chk("exc_status", bus.status_o, 32'h0000_8003);
        rd("exc_badv", 8, 32'h33);
        exc(5'd0, 32'h200, 1'b0, 32'h77);
        chk("exc2_epc", bus.epc_o, 32'hFC);
        chk("exc2_cause", bus.cause_o, 32'h8000_0000);
        rd("exc2_badv", 8, 32'h33);
        bus.eret_i = 1; tick(); bus.eret_i = 0;
        chk("eret1", bus.status_o, 32'h0000_8001);

        bus.we_i = 1; bus.waddr_i = 14; bus.wdata_i = 32'h55;
        exc(5'd12, 32'h300, 1'b0, 32'h0);
        bus.we_i = 0;
        chk("exc_vs_mtc0", bus.epc_o, 32'h300);
        chk("exc3_status", bus.status_o, 32'h0000_8003);
        bus.eret_i = 1; tick(); bus.eret_i = 0;
        chk("eret2", bus.status_o, 32'h0000_8001);

        bus.int_i = 4'b0101;
        tick();
        bus.we_i = 1; bus.waddr_i = 13; bus.wdata_i = 32'hFFFF_FFFF;
        rd("cause_bypass", 13, 32'h00C0_1730);
        tick();
        bus.we_i = 0;
        chk("cause_wr", bus.cause_o, 32'h00C0_1730);
        mtc0(15, 32'h1234_5678);
        rd("prid_ro", 15, PRID);
        mtc0(3, 32'hDEAD_BEEF);
        rd("unmapped", 3, 32'd0);

        idle();
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 400; i++) begin
            bus.int_i       = HW'($urandom);
            bus.we_i        = $urandom_range(0, 1) == 1;
            bus.waddr_i     = 5'(addrs[$urandom_range(0, 9)]);
            bus.wdata_i     = (bus.waddr_i inside {5'd9, 5'd11}) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.raddr_i     = 5'(addrs[$urandom_range(0, 9)]);
            bus.exc_valid_i = $urandom_range(0, 7) == 0;
            bus.exc_code_i  = ($urandom_range(0, 1) == 1) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
            bus.exc_pc_i    = $urandom & 32'hFFFF_FFFC;
            bus.exc_bd_i    = $urandom_range(0, 1) == 1;
            bus.exc_badvaddr_i = $urandom;
            bus.eret_i      = $urandom_range(0, 7) == 0;
            #1;
            chk("rnd_data", bus.data_o, m_read());
            chk("rnd_status", bus.status_o, m_status);
            chk("rnd_cause", bus.cause_o, m_cause());
            chk("rnd_epc", bus.epc_o, m_epc);
            chk("rnd_pend", bus.int_pending_o, m_pend);
            chk("rnd_timer", bus.timer_int_o, m_timer);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
